// File: rtl/slot_alloc8.sv
`default_nettype none
// ============================================================================
// Module   : slot_alloc8
// Purpose  : Eight-slot allocation bitmap: lowest-free grant, release, flush.
// Revision : 1.0
// ============================================================================
module slot_alloc8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       alloc_req,
  output logic       alloc_gnt,
  output logic [2:0] alloc_id,
  input  logic       free_valid,
  input  logic [2:0] free_id,
  input  logic       flush,
  output logic [7:0] used,
  output logic       full,
  output logic       empty,
  output logic [3:0] count,
  output logic       err_dfree
);

  localparam int unsigned NUM_SLOTS = 8;

  logic [7:0] alloc_mask;
  logic [7:0] free_mask;
  logic       free_hit;
  logic       legal_free;
  logic       illegal_free;

  assign full  = &used;
  assign empty = ~|used;

  // Scan from the top so the lowest free index wins; defaults to 0 when full.
  always_comb begin
    alloc_id = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!used[i]) alloc_id = 3'(i);
    end
  end

  assign alloc_gnt    = alloc_req & ~full & ~flush;
  assign free_hit     = used[free_id];
  assign legal_free   = free_valid & free_hit;
  assign illegal_free = free_valid & ~free_hit & ~flush;

  assign alloc_mask = alloc_gnt  ? (8'h01 << alloc_id) : 8'h00;
  assign free_mask  = legal_free ? (8'h01 << free_id)  : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      used      <= 8'h00;
      count     <= 4'd0;
      err_dfree <= 1'b0;
    end else if (flush) begin
      used      <= 8'h00;
      count     <= 4'd0;
      err_dfree <= 1'b0;
    end else begin
      used      <= (used & ~free_mask) | alloc_mask;
      count     <= count + {3'd0, alloc_gnt} - {3'd0, legal_free};
      err_dfree <= illegal_free;
    end
  end

endmodule
`default_nettype wire
